// File: rtl/lcd_byte_writer.sv
// ============================================================================
// Module      : lcd_byte_writer
// Description : Splits one command/data byte into two LCD nibbles and drives
//               RS/RW/DATA/E with setup, pulse, hold, gap and wait timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_byte_writer #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 12,
    parameter int unsigned T_HOLD  = 1,
    parameter int unsigned T_GAP   = 50,
    parameter int unsigned T_WAIT  = 2000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oDone,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_HI_SETUP = 4'd1,
        S_HI_PULSE = 4'd2,
        S_HI_HOLD  = 4'd3,
        S_GAP      = 4'd4,
        S_LO_SETUP = 4'd5,
        S_LO_PULSE = 4'd6,
        S_LO_HOLD  = 4'd7,
        S_WAIT     = 4'd8
    } state_t;

    // Each timed state ends when the counter reaches its duration minus one.
    localparam logic [15:0] c_SETUP_LAST = 16'(T_SETUP - 1);
    localparam logic [15:0] c_PULSE_LAST = 16'(T_PULSE - 1);
    localparam logic [15:0] c_HOLD_LAST  = 16'(T_HOLD - 1);
    localparam logic [15:0] c_GAP_LAST   = 16'(T_GAP - 1);
    localparam logic [15:0] c_WAIT_LAST  = 16'(T_WAIT - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_count;
    logic [3:0]  r_lowNibble;
    logic        r_ready;
    logic        r_done;
    logic        r_lcdE;
    logic        r_lcdRS;
    logic [3:0]  r_lcdData;
    logic        w_accept;
    logic        w_loadLow;

    assign w_accept  = iValid && r_ready && (r_state == S_IDLE);
    assign w_loadLow = (r_state == S_GAP) && (w_nextState == S_LO_SETUP);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_count <= 16'd0;
        end else begin
            r_state <= w_nextState;
            if ((w_nextState != r_state) || (r_state == S_IDLE)) begin
                r_count <= 16'd0;
            end else begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:     if (w_accept)                  w_nextState = S_HI_SETUP;
            S_HI_SETUP: if (r_count == c_SETUP_LAST)   w_nextState = S_HI_PULSE;
            S_HI_PULSE: if (r_count == c_PULSE_LAST)   w_nextState = S_HI_HOLD;
            S_HI_HOLD:  if (r_count == c_HOLD_LAST)    w_nextState = S_GAP;
            S_GAP:      if (r_count == c_GAP_LAST)     w_nextState = S_LO_SETUP;
            S_LO_SETUP: if (r_count == c_SETUP_LAST)   w_nextState = S_LO_PULSE;
            S_LO_PULSE: if (r_count == c_PULSE_LAST)   w_nextState = S_LO_HOLD;
            S_LO_HOLD:  if (r_count == c_HOLD_LAST)    w_nextState = S_WAIT;
            S_WAIT:     if (r_count == c_WAIT_LAST)    w_nextState = S_IDLE;
            default:                                   w_nextState = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_lcdE      <= 1'b0;
            r_lcdRS     <= 1'b0;
            r_lcdData   <= 4'd0;
            r_lowNibble <= 4'd0;
        end else begin
            r_ready <= (w_nextState == S_IDLE);
            r_done  <= (r_state == S_WAIT) && (w_nextState == S_IDLE);
            r_lcdE  <= (w_nextState == S_HI_PULSE) || (w_nextState == S_LO_PULSE);
            if (w_accept) begin
                r_lowNibble <= iData[3:0];
                r_lcdData   <= iData[7:4];
                r_lcdRS     <= iRS;
            end else if (w_loadLow) begin
                r_lcdData <= r_lowNibble;
            end
        end
    end

    assign oReady    = r_ready;
    assign oDone     = r_done;
    assign oLCD_E    = r_lcdE;
    assign oLCD_RS   = r_lcdRS;
    assign oLCD_RW   = 1'b0;
    assign oLCD_Data = r_lcdData;

endmodule

`default_nettype wire

// File: tb/tb_lcd_byte_writer.sv
// ============================================================================
// Module      : tb_lcd_byte_writer
// Description : Self-checking bench; instance 0 uses default timing,
//               instance 1 uses all-ones timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_byte_writer;

    typedef struct packed {
        logic       ready;
        logic       done;
        logic       e;
        logic       rs;
        logic [3:0] data;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       vld[2];
    logic       rsIn[2];
    logic [7:0] dat[2];
    logic       dRdy[2];
    logic       dDone[2];
    logic       dE[2];
    logic       dRS[2];
    logic       dRW[2];
    logic [3:0] dD[2];

    int cS[2] = '{2, 1};
    int cP[2] = '{12, 1};
    int cH[2] = '{1, 1};
    int cG[2] = '{50, 1};
    int cW[2] = '{2000, 1};

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         act[2];
    int         acc[2];
    logic [7:0] mb[2];
    logic       mrs[2];
    logic       expRdy[2];
    int         rises[2];
    int         dones[2];
    logic       ePrev[2];

    always #5 Clock = ~Clock;

    lcd_byte_writer dut0 (
        .Clock(Clock), .Reset(Reset), .iData(dat[0]), .iRS(rsIn[0]), .iValid(vld[0]),
        .oReady(dRdy[0]), .oDone(dDone[0]), .oLCD_E(dE[0]), .oLCD_RS(dRS[0]),
        .oLCD_RW(dRW[0]), .oLCD_Data(dD[0])
    );

    lcd_byte_writer #(
        .T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1), .T_WAIT(1)
    ) dut1 (
        .Clock(Clock), .Reset(Reset), .iData(dat[1]), .iRS(rsIn[1]), .iValid(vld[1]),
        .oReady(dRdy[1]), .oDone(dDone[1]), .oLCD_E(dE[1]), .oLCD_RS(dRS[1]),
        .oLCD_RW(dRW[1]), .oLCD_Data(dD[1])
    );

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, i, cyc, got, want);
        end
    endtask

    // Expected outputs from the accept time and the timing windows alone.
    function automatic exp_t model(input int i);
        exp_t x;
        int d, half, busy, off;
        x = '0;
        x.ready = 1'b1;
        if (Reset && act[i]) begin
            d    = cyc - acc[i];
            half = cS[i] + cP[i] + cH[i] + cG[i];
            busy = 2 * (cS[i] + cP[i] + cH[i]) + cG[i] + cW[i];
            x.rs   = mrs[i];
            x.data = mb[i][3:0];
            if (d >= 1 && d <= busy) begin
                x.ready = 1'b0;
                off     = (d > half) ? d - half : d;
                x.data  = (d > half) ? mb[i][3:0] : mb[i][7:4];
                x.e     = (off > cS[i]) && (off <= cS[i] + cP[i]);
            end else if (d == busy + 1) begin
                x.done = 1'b1;
            end
        end
        return x;
    endfunction

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!Reset) begin
                act[i] <= 1'b0;
            end else if (vld[i] && expRdy[i]) begin
                act[i] <= 1'b1;
                acc[i] <= cyc;
                mb[i]  <= dat[i];
                mrs[i] <= rsIn[i];
            end
        end
    end

    always @(negedge Clock) begin
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            x = model(i);
            expRdy[i] = x.ready;
            chk("ready", i, 32'(dRdy[i]), 32'(x.ready));
            chk("done",  i, 32'(dDone[i]), 32'(x.done));
            chk("lcdE",  i, 32'(dE[i]), 32'(x.e));
            chk("lcdRS", i, 32'(dRS[i]), 32'(x.rs));
            chk("lcdRW", i, 32'(dRW[i]), 32'd0);
            chk("lcdD",  i, 32'(dD[i]), 32'(x.data));
            if (dE[i] === 1'b1 && ePrev[i] !== 1'b1) rises[i]++;
            if (dDone[i] === 1'b1) dones[i]++;
            ePrev[i] = dE[i];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #2;
    endtask

    task automatic send(input int i, input logic [7:0] b, input logic r);
        vld[i] = 1'b1; dat[i] = b; rsIn[i] = r;
        tick(1);
        vld[i] = 1'b0;
    endtask

    task automatic waitDone(input int i, input int bound, input bit churn, output int lat);
        lat = -1;
        for (int n = 0; n < bound; n++) begin
            @(negedge Clock);
            if (dDone[i] === 1'b1) begin
                lat = cyc - acc[i];
                break;
            end
            if (churn) begin dat[i] = 8'($urandom); rsIn[i] = 1'($urandom); end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL doneTimeout inst%0d: got no oDone expected one within %0d cycles", i, bound);
        end
    endtask

    task automatic eWidth(input int i, input int bound, input bit churn,
                          output int w, output logic [3:0] dv, output logic rv);
        w = 0; dv = 4'd0; rv = 1'b0;
        for (int n = 0; n < bound && w == 0; n++) begin
            @(negedge Clock);
            if (churn) begin dat[i] = 8'($urandom); rsIn[i] = 1'($urandom); end
            if (dE[i] === 1'b1) begin
                dv = dD[i]; rv = dRS[i]; w = 1;
                for (int m = 0; m < bound; m++) begin
                    @(negedge Clock);
                    if (dE[i] === 1'b1) w++;
                    else break;
                end
            end
        end
        if (w == 0) begin
            checks++; errors++;
            $display("FAIL eTimeout inst%0d: got no E pulse expected one within %0d cycles", i, bound);
        end
    endtask

    initial begin
        int lat, w, a1, a2, r0, d0;
        logic [3:0] dv;
        logic rv;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; dat[i] = 8'd0; rsIn[i] = 1'b0; expRdy[i] = 1'b1;
            act[i] = 1'b0; acc[i] = 0; mb[i] = 8'd0; mrs[i] = 1'b0;
            rises[i] = 0; dones[i] = 0; ePrev[i] = 1'b0;
        end
        #1 Reset = 1'b0;
        tick(4);
        Reset = 1'b1;

        // Reset state and idle stability
        @(negedge Clock);
        chk("rstReady", 0, 32'(dRdy[0]), 32'd1);
        chk("rstDone", 0, 32'(dDone[0]), 32'd0);
        chk("rstE", 0, 32'(dE[0]), 32'd0);
        chk("rstData", 0, 32'(dD[0]), 32'd0);
        tick(100);
        @(negedge Clock);
        chk("idleReady", 0, 32'(dRdy[0]), 32'd1);
        chk("idleData", 0, 32'(dD[0]), 32'd0);

        // Single data write 0xA5
        tick(1);
        d0 = dones[0];
        send(0, 8'hA5, 1'b1);
        eWidth(0, 100, 1'b0, w, dv, rv);
        chk("hiWidth", 0, 32'(w), 32'd12);
        chk("hiNib", 0, 32'(dv), 32'hA);
        chk("hiRS", 0, 32'(rv), 32'd1);
        eWidth(0, 200, 1'b0, w, dv, rv);
        chk("loWidth", 0, 32'(w), 32'd12);
        chk("loNib", 0, 32'(dv), 32'h5);
        waitDone(0, 3000, 1'b0, lat);
        chk("doneLat", 0, 32'(lat), 32'd2081);
        tick(50);
        chk("doneOnce", 0, 32'(dones[0] - d0), 32'd1);

        // Command write with input churn after accept
        send(0, 8'h28, 1'b0);
        eWidth(0, 100, 1'b1, w, dv, rv);
        chk("cmdHiNib", 0, 32'(dv), 32'h2);
        chk("cmdHiRS", 0, 32'(rv), 32'd0);
        eWidth(0, 200, 1'b1, w, dv, rv);
        chk("cmdLoNib", 0, 32'(dv), 32'h8);
        chk("cmdLoRS", 0, 32'(rv), 32'd0);
        waitDone(0, 3000, 1'b1, lat);
        tick(1);

        // Back-to-back with iValid held
        r0 = rises[0];
        vld[0] = 1'b1; dat[0] = 8'h01; rsIn[0] = 1'b0;
        tick(1);
        a1 = acc[0];
        dat[0] = 8'h0C;
        for (int n = 0; n < 3000; n++) begin
            tick(1);
            if (acc[0] != a1) break;
        end
        a2 = acc[0];
        vld[0] = 1'b0;
        chk("b2bSpacing", 0, 32'(a2 - a1), 32'd2081);
        waitDone(0, 3000, 1'b0, lat);
        chk("b2bLat", 0, 32'(lat), 32'd2081);
        chk("b2bPulses", 0, 32'(rises[0] - r0), 32'd4);

        // All-ones timing instance
        tick(1);
        r0 = rises[1];
        send(1, 8'hFF, 1'b1);
        waitDone(1, 50, 1'b0, lat);
        chk("shortLat", 1, 32'(lat), 32'd9);
        chk("shortPulses", 1, 32'(rises[1] - r0), 32'd2);

        // Randomised traffic on the fast instance
        for (int n = 0; n < 400; n++) begin
            tick(1);
            vld[1]  = ($urandom_range(0, 2) == 0);
            dat[1]  = 8'($urandom);
            rsIn[1] = 1'($urandom);
        end
        vld[1] = 1'b0;
        tick(20);

        // Reset mid-pulse and mid-wait
        d0 = dones[0];
        send(0, 8'h77, 1'b1);
        tick(3);
        chk("ePreRst", 0, 32'(dE[0]), 32'd1);
        Reset = 1'b0;
        #1;
        chk("eAsyncRst", 0, 32'(dE[0]), 32'd0);
        chk("rdyAsyncRst", 0, 32'(dRdy[0]), 32'd1);
        tick(2);
        Reset = 1'b1;
        tick(1);
        send(0, 8'h96, 1'b0);
        tick(200);
        Reset = 1'b0;
        #1;
        chk("rdyWaitRst", 0, 32'(dRdy[0]), 32'd1);
        tick(2);
        Reset = 1'b1;
        tick(2100);
        chk("noDoneAfterRst", 0, 32'(dones[0] - d0), 32'd0);
        send(0, 8'h3C, 1'b1);
        eWidth(0, 100, 1'b0, w, dv, rv);
        chk("postRstNib", 0, 32'(dv), 32'h3);
        waitDone(0, 3000, 1'b0, lat);
        chk("postRstLat", 0, 32'(lat), 32'd2081);
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_byte_writer.md
# lcd_byte_writer

Upstream transfer stage of the Spartan-3E character-LCD path. It accepts one command or data byte through a valid/ready handshake and splits it into two 4-bit nibbles, upper nibble first. It drives RS, RW, the data nibble and the E strobe with the LCD's setup, pulse, hold, inter-nibble and post-byte timing. The LCD init/message sequencer sits upstream of this block; the LCD pins sit downstream.

## Interface
Parameters:
- T_SETUP, default 2: cycles RS/data are stable before E rises (40 ns at 50 MHz).
- T_PULSE, default 12: cycles E is high (240 ns).
- T_HOLD, default 1: cycles data is held after E falls (20 ns).
- T_GAP, default 50: cycles between the nibbles (1 µs).
- T_WAIT, default 2000: cycles after the lower nibble before the next byte (40 µs).

Ports:
- Clock, in, 1: single clock for all logic, rising edge.
- Reset, in, 1: reset; asynchronous, active-low.
- iData, in, 8: byte to write.
- iRS, in, 1: 0 = command, 1 = data.
- iValid, in, 1: request from upstream.
- oReady, out, 1: block is idle and will accept.
- oDone, out, 1: one-cycle pulse when the byte is complete.
- oLCD_E, out, 1: LCD enable strobe.
- oLCD_RS, out, 1: LCD register select.
- oLCD_RW, out, 1: tied to 0 (write only).
- oLCD_Data, out, 4: LCD data nibble (SF_D[11:8]).

## Operation
- Every timing parameter must be at least 1 and at most 65535. The internal cycle counter is 16 bits and clears on every state change.
- All outputs are registered. oLCD_RW is constant 0.
- Reset values: state IDLE, oReady=1, oDone=0, oLCD_E=0, oLCD_RS=0, oLCD_Data=0, counter 0.
- Handshake: a transfer is accepted on a rising edge where iValid=1 and oReady=1. On that edge iData and iRS are latched. iData/iRS changes after acceptance have no effect.
- While busy, oReady=0 and iValid is ignored; nothing is queued.
- States and transitions:
  - IDLE: oReady=1. On accept, go to HI_SETUP.
  - HI_SETUP: oLCD_Data=iData[7:4], oLCD_RS=latched RS, E=0. Lasts T_SETUP cycles, then HI_PULSE.
  - HI_PULSE: E=1 for T_PULSE cycles, then HI_HOLD.
  - HI_HOLD: E=0, data unchanged, for T_HOLD cycles, then GAP.
  - GAP: E=0 for T_GAP cycles, then LO_SETUP.
  - LO_SETUP, LO_PULSE, LO_HOLD: same as the HI_ states, using iData[3:0].
  - WAIT: E=0 for T_WAIT cycles, then IDLE. oDone=1 and oReady=1 together on the first IDLE cycle.
- In IDLE, oLCD_Data and oLCD_RS keep their last driven values.
- Asserting Reset in any state forces the reset values immediately, including oLCD_E=0 mid-pulse. The in-flight byte is dropped and no oDone is produced.

## Timing
- An accept at edge k gives these cycle ranges:
  - Upper nibble valid: k+1 to k+T_SETUP+T_PULSE+T_HOLD+T_GAP.
  - E high for the upper nibble: cycles k+T_SETUP+1 to k+T_SETUP+T_PULSE.
  - The lower nibble follows the same pattern, offset by S+P+H+G.
- Busy length (oReady=0) is 2·(T_SETUP+T_PULSE+T_HOLD)+T_GAP+T_WAIT cycles. With the defaults this is 2080 cycles.
- oDone is high in cycle k+busy+1, together with oReady=1.
- Back-to-back transfers: if iValid is held high, the next byte is accepted on the edge that ends the oDone cycle. Accepts are therefore spaced busy+1 cycles apart.
- Between E pulses, E is low for exactly T_HOLD+T_GAP+T_SETUP cycles.
- There are never two E pulses without the full gap between them, and E is never high in IDLE, GAP or WAIT.

## Test plan
- Reset: release Reset with iValid=0 → oReady=1, oDone=0, E=0, RS=0, Data=0, RW=0. Hold for 100 cycles → no change.
- Single data write, defaults: iData=0xA5, iRS=1.
  - Data=0xA with RS=1 for 2 cycles, then E high for exactly 12 cycles, then 51 cycles with E=0.
  - Data=0x5 for 2 cycles, then E high for 12 cycles.
  - oDone pulses exactly once, 2081 cycles after accept.
- Command write with input churn: iData=0x28, iRS=0, with iData/iRS randomised after accept → nibbles 0x2 then 0x8 with RS=0.
- Back-to-back: iValid held for 0x01 then 0x0C → second accept on the oDone cycle; exactly 4 E pulses total; no overlap.
- Short parameters: all parameters set to 1, write 0xFF → E pulses are 1 cycle wide, separated by 3 low cycles; oDone arrives 9 cycles after accept.
- Reset mid-operation: assert Reset during HI_PULSE and again during WAIT.
  - E goes low asynchronously with no oDone.
  - After release, a new write of 0x3C completes normally.
